// File: rtl/nios_qsys_loader_pkg.sv
// Shared types and constants for the on-chip memory loader.
// Holds the FSM state encoding and default geometry.
package nios_qsys_loader_pkg;

  localparam int DEF_DEPTH  = 45000;
  localparam int DEF_ADDR_W = 16;
  localparam int DATA_W     = 32;
  localparam int BYTE_W     = 8;
  localparam int LANES      = DATA_W / BYTE_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_FINISH
  } state_e;

endpackage

// File: rtl/nios_qsys_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words.
// word is complete (including the current byte) when word_valid is high.
module nios_qsys_byte_packer
  import nios_qsys_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              accept,
  input  logic [BYTE_W-1:0] in_data,
  output logic [DATA_W-1:0] word,
  output logic              word_valid
);

  logic [1:0]        cnt;
  logic [DATA_W-1:0] lanes;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt   <= '0;
      lanes <= '0;
    end else if (accept) begin
      lanes[cnt*BYTE_W +: BYTE_W] <= in_data;
      cnt <= cnt + 2'd1;
    end
  end

  // Top lane bypasses the register so the word leaves on the 4th byte.
  always_comb begin
    word = lanes;
    word[DATA_W-1 -: BYTE_W] = in_data;
  end

  assign word_valid = accept && (cnt == 2'd3);

endmodule

// File: rtl/nios_qsys_mem_loader.sv
// Loads a byte stream into on-chip memory, then reads it back
// and compares additive checksums of written and read words.
module nios_qsys_mem_loader
  import nios_qsys_loader_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              error
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

  state_e            state;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] count;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] wsum;
  logic [DATA_W-1:0] rsum;
  logic [DATA_W-1:0] word;
  logic              word_valid;
  logic [ADDR_W:0]   end_sum;
  logic              bad_req;
  logic              start_ok;
  logic [DATA_W-1:0] rsum_next;

  assign end_sum  = {1'b0, base_addr} + {1'b0, word_count};
  assign bad_req  = (word_count == '0) || (end_sum > LIMIT);
  assign start_ok = (state == S_IDLE) && start && !bad_req;

  assign in_ready  = (state == S_FILL);
  assign busy      = (state != S_IDLE);
  assign rsum_next = rsum + mem_readdata;

  nios_qsys_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_ok),
    .accept     (in_valid && in_ready),
    .in_data    (in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      base           <= '0;
      count          <= '0;
      idx            <= '0;
      wsum           <= '0;
      rsum           <= '0;
      mem_address    <= '0;
      mem_byteenable <= '0;
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_writedata  <= '0;
      done           <= 1'b0;
      pass           <= 1'b0;
      error          <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start && bad_req) begin
            error <= 1'b1;
          end else if (start_ok) begin
            base  <= base_addr;
            count <= word_count;
            idx   <= '0;
            wsum  <= '0;
            rsum  <= '0;
            pass  <= 1'b0;
            state <= S_FILL;
          end
        end
        S_FILL: begin
          if (word_valid) begin
            mem_chipselect <= 1'b1;
            mem_write      <= 1'b1;
            mem_byteenable <= 4'hF;
            mem_address    <= base + idx;
            mem_writedata  <= word;
            state          <= S_WRITE;
          end
        end
        S_WRITE: begin
          wsum      <= wsum + mem_writedata;
          mem_write <= 1'b0;
          if (idx + 1'b1 == count) begin
            idx         <= '0;
            mem_address <= base;
            state       <= S_READ;
          end else begin
            idx            <= idx + 1'b1;
            mem_chipselect <= 1'b0;
            state          <= S_FILL;
          end
        end
        S_READ: begin
          // Data for the read issued last cycle arrives now.
          if (idx != '0) rsum <= rsum_next;
          if (idx == count - 1'b1) begin
            mem_chipselect <= 1'b0;
            state          <= S_DRAIN;
          end else begin
            mem_address <= base + idx + 1'b1;
          end
          idx <= idx + 1'b1;
        end
        S_DRAIN: begin
          rsum  <= rsum_next;
          pass  <= (rsum_next == wsum);
          done  <= 1'b1;
          state <= S_FINISH;
        end
        S_FINISH: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nios_qsys_mem_loader.sv
// Randomised scoreboard bench for the memory loader.
// Expected writes, pass flags and errors come from a byte-level model.
module tb_nios_qsys_mem_loader;

  localparam int DEPTH = 45000;
  localparam int AW    = 16;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] word_count;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] mem_address;
  logic [3:0]    mem_byteenable;
  logic          mem_chipselect;
  logic          mem_write;
  logic [31:0]   mem_writedata;
  logic [31:0]   mem_readdata;
  logic          busy;
  logic          done;
  logic          pass;
  logic          error;

  nios_qsys_mem_loader #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .word_count     (word_count),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_readdata   (mem_readdata),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .error          (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] rdata = '0;
  bit          corrupt = 1'b0;

  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) mem[mem_address] <= mem_writedata;
      else rdata <= corrupt ? 32'h0 : mem[mem_address];
    end
  end
  assign mem_readdata = rdata;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  wr_t wq[$];
  bit  pq[$];
  int  n_err_exp = 0;
  bit  last_pass = 1'b0;
  int  n_chk = 0;
  int  n_fail = 0;
  int  c0 = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_write) chk("write_without_cs", mem_chipselect, 1);
      if (mem_chipselect && mem_write) begin
        if (wq.size() == 0) begin
          chk("unexpected_write", mem_write, 0);
        end else begin
          wr_t e;
          e = wq.pop_front();
          chk("wr_addr", mem_address, e.a);
          chk("wr_data", mem_writedata, e.d);
          chk("wr_be", mem_byteenable, 4'hF);
        end
      end
      if (done) begin
        if (pq.size() == 0) chk("unexpected_done", done, 0);
        else chk("pass", pass, pq.pop_front());
      end
      if (error) begin
        if (n_err_exp == 0) begin
          chk("unexpected_error", error, 0);
        end else begin
          n_err_exp--;
          chk("error_busy", busy, 0);
        end
      end
    end
  end

  task automatic do_start(int base, int count);
    base_addr  = AW'(base);
    word_count = AW'(count);
    start      = 1'b1;
    c0         = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] bq[$], bit tog, bit glitch);
    bit ph = 1'b1;
    foreach (bq[i]) begin
      bit acc;
      int guard = 0;
      in_data = bq[i];
      do begin
        in_valid = tog ? ph : 1'b1;
        ph = !ph;
        start = glitch && ($urandom_range(0, 2) == 0);
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk); #1;
        guard++;
      end while (!acc && guard < 50);
      if (!acc) chk("byte_accept_timeout", acc, 1);
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic do_load(int base, int count, input logic [7:0] bq[$],
                         bit tog, bit glitch, bit corr, bit lat);
    logic [31:0] sum = 0;
    int t = 0;
    int cd;
    for (int w = 0; w < count; w++) begin
      wr_t e;
      e.a = AW'(base + w);
      e.d = bq[4*w] + 256 * bq[4*w+1] + 65536 * bq[4*w+2]
          + 16777216 * bq[4*w+3];
      sum = sum + e.d;
      wq.push_back(e);
    end
    last_pass = corr ? (sum == 0) : 1'b1;
    pq.push_back(last_pass);
    corrupt = corr;
    do_start(base, count);
    send_bytes(bq, tog, glitch);
    do begin
      @(negedge clk);
      t++;
    end while (!done && t < 12 * count + 40);
    cd = cyc;
    if (!done) chk("done_timeout", done, 1);
    else if (lat) chk("latency", cd - c0, 6 * count + 2);
    @(posedge clk); #1;
    corrupt = 1'b0;
  endtask

  task automatic do_reject(int base, int count);
    n_err_exp++;
    do_start(base, count);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reject_busy", busy, 0);
      chk("reject_cs", mem_chipselect, 0);
    end
    chk("reject_pass_kept", pass, last_pass);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] q[$];
    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    in_data = '0; base_addr = '0; word_count = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs",
        {in_ready, mem_chipselect, mem_write, busy, done, pass, error,
         mem_address, mem_byteenable, mem_writedata}, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    do_load(0, 2, q, 1'b0, 1'b0, 1'b0, 1'b1);
    do_reject(44999, 2);
    do_reject(123, 0);
    q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    do_load(44998, 2, q, 1'b0, 1'b0, 1'b0, 1'b1);
    q = {8'h9A, 8'h5C, 8'h13, 8'hE7};
    do_load(77, 1, q, 1'b0, 1'b0, 1'b1, 1'b1);

    do_start(0, 1);
    q = {8'h5A, 8'hA5};
    send_bytes(q, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midfill_reset",
        {in_ready, mem_chipselect, mem_write, busy, done, pass, error,
         mem_address, mem_byteenable, mem_writedata}, 0);
    reset = 1'b0;
    last_pass = 1'b0;
    q = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_load(0, 1, q, 1'b0, 1'b0, 1'b0, 1'b1);

    q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    do_load(0, 2, q, 1'b1, 1'b1, 1'b0, 1'b0);

    for (int n = 0; n < 8; n++) begin
      int cnt = $urandom_range(1, 4);
      int b = $urandom_range(0, DEPTH - cnt);
      bit tog = $urandom_range(0, 1) == 1;
      bit cor = $urandom_range(0, 3) == 0;
      q = {};
      for (int i = 0; i < 4 * cnt; i++) q.push_back(8'($urandom));
      do_load(b, cnt, q, tog, tog, cor, !tog);
      if ($urandom_range(0, 1) == 1) begin
        int k = $urandom_range(0, 3);
        do_reject(DEPTH - k, k + 1 + $urandom_range(0, 5));
      end
    end

    repeat (3) @(posedge clk);
    chk("writes_left", wq.size(), 0);
    chk("passes_left", pq.size(), 0);
    chk("errors_left", n_err_exp, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
